// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage definitions: FSM states, NOP encoding, reset PC default and
// the instruction field positions also consumed by control and immediate decode.
package fetch_unit_pkg;

    localparam int unsigned DEFAULT_XLEN = 32;
    localparam int unsigned ILEN         = 32;

    localparam logic [31:0]     DEFAULT_RESET_PC = 32'h0000_0000;
    localparam logic [ILEN-1:0] NOP_INSTR        = 32'h0000_0013;

    localparam int unsigned OP_LSB = 0;
    localparam int unsigned OP_W   = 7;
    localparam int unsigned F3_LSB = 12;
    localparam int unsigned F3_W   = 3;
    localparam int unsigned F7_BIT = 30;

    typedef enum logic [1:0] {
        FETCH = 2'd0,
        WAIT  = 2'd1,
        VALID = 2'd2
    } fetchState_e;

    typedef struct packed {
        logic [OP_W-1:0] op;
        logic [F3_W-1:0] f3;
        logic            f7;
    } instrFields_t;

    function automatic instrFields_t decodeFields(input logic [ILEN-1:0] word);
        instrFields_t f;
        f.op = word[OP_LSB +: OP_W];
        f.f3 = word[F3_LSB +: F3_W];
        f.f7 = word[F7_BIT];
        return f;
    endfunction

endpackage

// File: rtl/fetch_unit_pc_next_mux.sv
// Next-PC selection for the fetch stage: sequential increment, branch/jump target
// or flush redirect, with word alignment of redirects and a misalignment flag.
module fetch_unit_pc_next_mux
    import fetch_unit_pkg::*;
#(
    parameter int unsigned XLEN = DEFAULT_XLEN
) (
    input  logic [XLEN-1:0] basePc,
    input  logic [XLEN-1:0] seqPc,
    input  logic [XLEN-1:0] pcTarget,
    input  logic [XLEN-1:0] flushPc,
    input  logic            useFlush,
    input  logic            takeTarget,
    output logic [XLEN-1:0] incPc_c,
    output logic [XLEN-1:0] nextPc_c,
    output logic            misaligned_c
);

    logic [XLEN-1:0] rawTarget;
    logic            redirect;

    // Flush outranks a taken branch; both are forced onto a word boundary.
    always_comb begin
        incPc_c      = basePc + XLEN'(4);
        redirect     = useFlush || takeTarget;
        rawTarget    = useFlush ? flushPc : pcTarget;
        misaligned_c = redirect && (rawTarget[1:0] != 2'b00);
        nextPc_c     = redirect ? {rawTarget[XLEN-1:2], 2'b00} : seqPc;
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC ownership, single-outstanding imem handshake,
// instruction holding register and next-PC selection with flush redirect.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter int unsigned     XLEN     = DEFAULT_XLEN,
    parameter logic [XLEN-1:0] RESET_PC = XLEN'(DEFAULT_RESET_PC)
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_gnt,
    input  logic            imem_rvalid,
    input  logic [ILEN-1:0] imem_rdata,
    input  logic            out_ready,
    input  logic            pcSrc,
    input  logic [XLEN-1:0] pcTarget,
    input  logic            flush,
    input  logic [XLEN-1:0] flush_pc,
    output logic            instr_valid,
    output logic [ILEN-1:0] instr,
    output logic [XLEN-1:0] pc,
    output logic [XLEN-1:0] pcPlus4,
    output logic [OP_W-1:0] op,
    output logic [F3_W-1:0] f3,
    output logic            f7,
    output logic            misaligned
);

    fetchState_e     state, stateN;
    logic [XLEN-1:0] fetchPc, fetchPcN;
    logic [XLEN-1:0] pcQ, pcN;
    logic [XLEN-1:0] pcPlus4Q, pcPlus4N;
    logic [ILEN-1:0] instrQ, instrN;
    logic            kill, killN;
    logic            validQ, validN;
    logic            misQ, misN;
    logic            reqQ, reqN;

    logic [XLEN-1:0] incPc;
    logic [XLEN-1:0] nextPc;
    logic            misalignedNext;
    logic            takeTarget;
    instrFields_t    fields;

    // pcSrc only matters when the held instruction is being retired.
    assign takeTarget = (state == VALID) && out_ready && pcSrc;

    fetch_unit_pc_next_mux #(
        .XLEN (XLEN)
    ) u_pcNextMux (
        .basePc       (fetchPc),
        .seqPc        (pcPlus4Q),
        .pcTarget     (pcTarget),
        .flushPc      (flush_pc),
        .useFlush     (flush),
        .takeTarget   (takeTarget),
        .incPc_c      (incPc),
        .nextPc_c     (nextPc),
        .misaligned_c (misalignedNext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FETCH;
            fetchPc  <= RESET_PC;
            pcQ      <= RESET_PC;
            pcPlus4Q <= RESET_PC + XLEN'(4);
            instrQ   <= NOP_INSTR;
            kill     <= 1'b0;
            validQ   <= 1'b0;
            misQ     <= 1'b0;
            reqQ     <= 1'b1;
        end else begin
            state    <= stateN;
            fetchPc  <= fetchPcN;
            pcQ      <= pcN;
            pcPlus4Q <= pcPlus4N;
            instrQ   <= instrN;
            kill     <= killN;
            validQ   <= validN;
            misQ     <= misN;
            reqQ     <= reqN;
        end
    end

    // Flush wins in every state; a kill marks the one outstanding response as stale.
    always_comb begin
        stateN   = state;
        fetchPcN = fetchPc;
        pcN      = pcQ;
        pcPlus4N = pcPlus4Q;
        instrN   = instrQ;
        killN    = kill;
        validN   = validQ;
        misN     = 1'b0;

        case (state)
            FETCH: begin
                if (imem_gnt) begin
                    stateN = WAIT;
                    killN  = flush;
                end
                if (flush) begin
                    fetchPcN = nextPc;
                    misN     = misalignedNext;
                end
            end
            WAIT: begin
                if (flush) begin
                    fetchPcN = nextPc;
                    misN     = misalignedNext;
                    if (imem_rvalid) begin
                        stateN = FETCH;
                        killN  = 1'b0;
                    end else begin
                        killN  = 1'b1;
                    end
                end else if (imem_rvalid) begin
                    if (kill) begin
                        killN  = 1'b0;
                        stateN = FETCH;
                    end else begin
                        instrN   = imem_rdata;
                        pcN      = fetchPc;
                        pcPlus4N = incPc;
                        validN   = 1'b1;
                        stateN   = VALID;
                    end
                end
            end
            VALID: begin
                if (flush || out_ready) begin
                    validN   = 1'b0;
                    fetchPcN = nextPc;
                    misN     = misalignedNext;
                    stateN   = FETCH;
                end
            end
            default: stateN = FETCH;
        endcase

        reqN = (stateN == FETCH);
    end

    assign fields      = decodeFields(instrQ);
    assign imem_req    = reqQ;
    assign imem_addr   = fetchPc;
    assign instr_valid = validQ;
    assign instr       = instrQ;
    assign pc          = pcQ;
    assign pcPlus4     = pcPlus4Q;
    assign op          = fields.op;
    assign f3          = fields.f3;
    assign f7          = fields.f7;
    assign misaligned  = misQ;

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios plus randomized memory/consumer traffic
// checked against a transaction-level model of the fetch stage.
module tb_fetch_unit;

    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam logic [31:0] NOP    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        out_ready;
    logic        pcSrc;
    logic [31:0] pcTarget;
    logic        flush;
    logic [31:0] flush_pc;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] pcPlus4;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic        f7;
    logic        misaligned;

    always #5 clk = ~clk;

    fetch_unit #(.XLEN(32), .RESET_PC(RST_PC)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_gnt(imem_gnt),
        .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata),
        .out_ready(out_ready), .pcSrc(pcSrc), .pcTarget(pcTarget),
        .flush(flush), .flush_pc(flush_pc),
        .instr_valid(instr_valid), .instr(instr), .pc(pc), .pcPlus4(pcPlus4),
        .op(op), .f3(f3), .f7(f7), .misaligned(misaligned)
    );

    int checks = 0;
    int errors = 0;

    // Model: holding an instruction, one request outstanding, whether its data is wanted.
    bit          mHold, mOut, mGood, mMis;
    logic [31:0] mNext, mPc, mInstr, mGntAddr;

    // Memory responder state.
    bit          pend, lateRv;
    int          pendCnt;
    logic [31:0] pendAddr;

    int gntRate, latMin, latMax, readyRate, srcRate, flushRate;

    function automatic logic [31:0] memWord(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0013;
    endfunction

    function automatic logic [31:0] align4(input logic [31:0] a);
        return a & 32'hFFFF_FFFC;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic checkOutputs();
        logic [31:0] w;
        w = mInstr;
        chk("instr_valid", 32'(instr_valid), 32'(mHold));
        chk("imem_req", 32'(imem_req), 32'(!mHold && !mOut));
        if (!mHold && !mOut) chk("imem_addr", imem_addr, mNext);
        chk("instr", instr, w);
        chk("pc", pc, mPc);
        chk("pcPlus4", pcPlus4, mPc + 32'd4);
        chk("op", 32'(op), 32'(w[6:0]));
        chk("f3", 32'(f3), 32'(w[14:12]));
        chk("f7", 32'(f7), 32'(w[30]));
        chk("misaligned", 32'(misaligned), 32'(mMis));
    endtask

    // One clock: check outputs, drive inputs, advance the model, then move past the edge.
    task automatic step(input bit forceFlush, input logic [31:0] forcePc,
                        input bit forceBr, input logic [31:0] forceTgt);
        bit          reqPhase, lateNow, fl;
        logic [31:0] fpc, tgt;
        checkOutputs();
        reqPhase = !mHold && !mOut;
        lateNow  = lateRv;
        lateRv   = 1'b0;

        imem_rvalid = 1'b0;
        imem_rdata  = $urandom;
        if (pend) begin
            pendCnt--;
            if (pendCnt == 0) begin
                imem_rvalid = 1'b1;
                imem_rdata  = memWord(pendAddr);
                pend        = 1'b0;
            end
        end
        if (lateNow) imem_rvalid = 1'b1;
        imem_gnt = reqPhase && !lateNow && ($urandom_range(99) < gntRate);
        if (imem_gnt) begin
            pend     = 1'b1;
            pendCnt  = $urandom_range(latMax, latMin);
            pendAddr = imem_addr;
        end

        out_ready = ($urandom_range(99) < readyRate);
        pcSrc     = ($urandom_range(99) < srcRate);
        tgt       = $urandom;
        if ($urandom_range(3) != 0) tgt[1:0] = 2'b00;
        if (forceBr) begin
            out_ready = 1'b1;
            pcSrc     = 1'b1;
            tgt       = forceTgt;
        end
        pcTarget = tgt;
        fpc = $urandom;
        if ($urandom_range(1) != 0) fpc[1:0] = 2'b00;
        fl = ($urandom_range(999) < flushRate);
        if (forceFlush) begin
            fl  = 1'b1;
            fpc = forcePc;
        end
        flush    = fl;
        flush_pc = fpc;

        mMis = 1'b0;
        if (fl) begin
            if (reqPhase && imem_gnt) begin
                mOut  = 1'b1;
                mGood = 1'b0;
            end else if (mOut && imem_rvalid) begin
                mOut = 1'b0;
            end else if (mOut) begin
                mGood = 1'b0;
            end
            mHold = 1'b0;
            mNext = align4(fpc);
            mMis  = (fpc[1:0] != 2'b00);
        end else if (reqPhase && imem_gnt) begin
            mOut     = 1'b1;
            mGood    = 1'b1;
            mGntAddr = mNext;
        end else if (mOut && imem_rvalid) begin
            mOut = 1'b0;
            if (mGood) begin
                mHold  = 1'b1;
                mPc    = mGntAddr;
                mInstr = memWord(mGntAddr);
            end
        end else if (mHold && out_ready) begin
            mHold = 1'b0;
            if (pcSrc) begin
                mNext = align4(tgt);
                mMis  = (tgt[1:0] != 2'b00);
            end else begin
                mNext = mPc + 32'd4;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic runUntilHold(input logic [31:0] addr, input int budget);
        for (int i = 0; i < budget && !(mHold && mPc == addr); i++) step(1'b0, 32'h0, 1'b0, 32'h0);
        chk("reach_hold_valid", 32'(instr_valid), 32'd1);
        chk("reach_hold_pc", pc, addr);
    endtask

    task automatic runUntilOut(input logic [31:0] addr, input int budget);
        for (int i = 0; i < budget && !(mOut && mGntAddr == addr); i++) step(1'b0, 32'h0, 1'b0, 32'h0);
        chk("reach_wait_req", 32'(imem_req), 32'd0);
        chk("reach_wait_addr", imem_addr, addr);
    endtask

    task automatic applyReset();
        rst_n = 1'b0;
        #2;
        chk("rst_instr_valid", 32'(instr_valid), 32'd0);
        chk("rst_instr", instr, NOP);
        chk("rst_pc", pc, RST_PC);
        chk("rst_misaligned", 32'(misaligned), 32'd0);
        chk("rst_imem_req", 32'(imem_req), 32'd1);
        chk("rst_imem_addr", imem_addr, RST_PC);
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        out_ready = 1'b0; pcSrc = 1'b0; pcTarget = 32'h0; flush = 1'b0; flush_pc = 32'h0;
        mHold = 1'b0; mOut = 1'b0; mGood = 1'b0; mMis = 1'b0;
        mNext = RST_PC; mPc = RST_PC; mInstr = NOP; mGntAddr = RST_PC;
        pend = 1'b0; pendCnt = 0; pendAddr = 32'h0; lateRv = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b1;
        imem_gnt = 1'b0; imem_rvalid = 1'b0; imem_rdata = 32'h0;
        out_ready = 1'b0; pcSrc = 1'b0; pcTarget = 32'h0; flush = 1'b0; flush_pc = 32'h0;
        #1;
        applyReset();

        // Zero-wait memory, always-ready consumer: 0,4,8,C back to back.
        gntRate = 100; latMin = 1; latMax = 1; readyRate = 100; srcRate = 0; flushRate = 0;
        run(12);

        // Consumer stalls while 0x10 is held.
        readyRate = 0;
        run(7);
        readyRate = 100;

        // Taken branch from 0x10, then a misaligned target.
        runUntilHold(32'h10, 10);
        step(1'b0, 32'h0, 1'b1, 32'h40);
        runUntilHold(32'h40, 10);
        step(1'b0, 32'h0, 1'b1, 32'h42);
        runUntilHold(32'h40, 10);

        // Flush in WAIT: stale response is dropped, refetch from 0x100.
        step(1'b0, 32'h0, 1'b1, 32'h8);
        latMin = 3; latMax = 3;
        runUntilOut(32'h8, 10);
        step(1'b1, 32'h100, 1'b0, 32'h0);
        runUntilHold(32'h100, 20);

        // Grant withheld for 4 cycles, then a slow response.
        gntRate = 0;
        run(5);
        gntRate = 100; latMin = 4; latMax = 4;
        runUntilHold(32'h104, 20);

        // PC wrap, then reset in WAIT with a late response after release.
        latMin = 1; latMax = 1;
        step(1'b0, 32'h0, 1'b1, 32'hFFFF_FFFC);
        runUntilHold(32'hFFFF_FFFC, 10);
        step(1'b0, 32'h0, 1'b0, 32'h0);
        latMin = 5; latMax = 5;
        runUntilOut(32'h0, 10);
        run(2);
        applyReset();
        lateRv = 1'b1;
        latMin = 1; latMax = 1;
        runUntilHold(RST_PC, 10);

        // Randomized traffic with flushes and branches.
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                gntRate   = $urandom_range(100, 30);
                latMin    = 1;
                latMax    = $urandom_range(4, 1);
                readyRate = $urandom_range(100, 20);
                srcRate   = $urandom_range(50, 0);
                flushRate = $urandom_range(60, 0);
            end
            step(1'b0, 32'h0, 1'b0, 32'h0);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

endmodule
